// File: rtl/segment_display_mux.sv
// Time-multiplexed common-anode 7-segment driver: scans one hex digit at a time,
// swaps in new values only at frame boundaries, with leading-zero blanking and per-digit blink.
module segment_display_mux #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]    prescale_q, prescale_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLK_W-1:0]    blinkCnt_q, blinkCnt_d;
  logic                blinkPhase_q, blinkPhase_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                frameTick_q, frameTick_d;

  logic                step;
  logic                frameWrap;
  logic [DIGITS-1:0]   zeroFrom;
  logic                allZero;
  logic [3:0]          nibble;
  logic                lzHere;
  logic                blinkHere;

  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    step      = (prescale_q == LAST_PRE);
    frameWrap = step && (idx_q == LAST_IDX);

    prescale_d = step ? '0 : prescale_q + PRE_W'(1);
    idx_d      = idx_q;
    if (step) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (frameWrap) begin
      if (blinkCnt_q == LAST_BLK) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + BLK_W'(1);
      end
    end

    // A load coinciding with the wrap bypasses the shadow so it shows next frame.
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
    if (frameWrap) begin
      if (load) begin
        active_d  = value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
    frameTick_d = frameWrap;
  end

  // zeroFrom[i] is set when every nibble from digit i upward is zero.
  always_comb begin
    zeroFrom = '0;
    allZero  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allZero     = allZero && (active_q[4*i +: 4] == 4'h0);
      zeroFrom[i] = allZero;
    end

    nibble    = 4'h0;
    lzHere    = 1'b0;
    blinkHere = 1'b0;
    an_d      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble    = active_q[4*i +: 4];
        lzHere    = zeroFrom[i];
        blinkHere = blink_mask[i];
        an_d[i]   = 1'b0;
      end
    end

    seg_d = hexToSeg(nibble);
    if ((blank_lz && (idx_q != '0) && lzHere) || (blinkHere && blinkPhase_q))
      seg_d = 7'b1111111;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_q   <= '0;
      idx_q        <= '0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
      frameTick_q  <= 1'b0;
    end else begin
      prescale_q   <= prescale_d;
      idx_q        <= idx_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frameTick_q  <= frameTick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frameTick_q;

endmodule

// File: doc/segment_display_mux.md
Name:
segment_display_mux

Overview:
Time-multiplexed driver for a common-anode multi-digit 7-segment display. It shows a packed hex value, one nibble per digit, and scans one digit at a time at a programmable rate. It adds tear-free frame-synchronous value updates, optional leading-zero blanking and per-digit blinking. It sits between the game/score logic and the board display pins, replacing per-digit combinational decoders.

Parameters:
DIGITS, 4, number of digits scanned (>=1); nibble i of value drives digit i, where digit 0 is least significant.
PRESCALE, 50000, clocks each digit stays lit (>=1).
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
load  in  1  one-cycle strobe; capture value
value  in  4*DIGITS  packed hex digits to display
blank_lz  in  1  1 = blank leading zero digits
blink_mask  in  DIGITS  1 = digit blinks
an  out  DIGITS  anode enables, active-low, one-hot-low while scanning
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
frame_tick  out  1  one-cycle pulse when scan wraps from digit DIGITS-1 to 0

Behaviour:
- Reset is synchronous active-low: on a clk edge with rst_n=0 every register is cleared. That gives an = all ones, seg = 7'b1111111, frame_tick = 0, prescaler = 0, idx = 0, shadow = 0, active = 0, pending = 0, blink counter = 0, blink_phase = 0. Reset mid-frame or mid-blink abandons the frame and any pending load.
- Prescaler counts 0..PRESCALE-1, then wraps. On the wrap cycle (the "step"), idx advances by 1, and from DIGITS-1 it wraps to 0. With PRESCALE=1, a step occurs every cycle.
- Frame wrap = step while idx == DIGITS-1. On that cycle, frame_tick is registered to 1 for exactly one cycle, and the blink counter increments.
- Blink counter runs 0..BLINK_FRAMES-1. At the end of that range it wraps to 0 and blink_phase toggles.
- load=1 captures value into shadow and sets pending.
- On a frame wrap:
  - if load is also high that cycle, active <= value directly and pending <= 0;
  - else if pending, active <= shadow and pending <= 0.
- The displayed value therefore changes only at frame boundaries; a digit never shows a mix of old and new values within a frame.
- Multiple loads within one frame: the last one wins.
- Per-digit decode uses nibble n = active[4*idx +: 4], encoded active-low:
  - digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000;
  - A-F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Blank (seg = 1111111) applies when either condition holds:
  - blank_lz=1, idx != 0, and every nibble from idx up to DIGITS-1 is 0. Digit 0 always shows, so a value of 0 displays a single "0".
  - blink_mask[idx]=1 and blink_phase=1.
- blank_lz and blink_mask are sampled live, not frame-synchronised.
- an and seg are registered. They reflect the idx value of the previous cycle, giving 1 cycle of latency after each step.
- an has exactly one bit low at all times after the first cycle out of reset; an and seg always switch on the same edge.
- DIGITS=1: idx stays 0, and every step is a frame wrap.

Test Plan:
1. DIGITS=4, PRESCALE=4, reset 3 cycles -> an=1111, seg=1111111. Release reset -> an steps 1110, 1101, 1011, 0111, with each state held 4 cycles; frame_tick pulses once every 16 cycles.
2. load value=16'h12AF mid-frame -> the current frame still shows the old value 0000. From the next frame, digit 0 shows 0001110 (F), digit 1 0001000 (A), digit 2 0100100 (2), digit 3 1111001 (1).
3. Two loads in one frame, 16'h1111 then 16'h2222 -> the next frame shows 2222. Load asserted on the frame-wrap cycle itself -> the value is displayed from the immediately following frame.
4. blank_lz=1, value=16'h0050 -> digits 3 and 2 show 1111111, digit 1 shows 0010010, digit 0 shows 1000000. value=0 -> only digit 0 is lit, showing 1000000.
5. BLINK_FRAMES=2, blink_mask=4'b0001, value=16'h8888 -> digit 0 alternates 0000000 and 1111111 every 2 frames; digits 1-3 stay 0000000.
6. Assert rst_n=0 for 1 cycle mid-frame with a pending load -> outputs return to reset values. After release the display shows 0 until a new load.
